// File: rtl/alu_div_if.sv
// Handshake and result bundle between the ALU sequencer and the restoring divider.
// The master drives the request; the slave (divider) returns the status and result.
interface alu_div_if #(parameter int WIDTH = 4);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic [2*WIDTH-1:0]   P;
    logic                 aDiv;
    logic                 div_zero;

    modport master (output start, A, B, input busy, P, aDiv, div_zero);
    modport slave  (input start, A, B, output busy, P, aDiv, div_zero);
endinterface

// File: rtl/alu_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned operands,
// packed {quotient, remainder} result with a one-cycle aDiv strobe.
module alu_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_div_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 adiv_q, adiv_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       ext;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       dvd_shift;
    logic                 qbit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        p_d       = p_q;
        dz_d      = dz_q;
        adiv_d    = 1'b0;

        // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
        ext       = {rem_q, dvd_q[WIDTH-1]};
        trial     = ext - {1'b0, dvs_q};
        qbit      = ~trial[WIDTH];
        dvd_shift = {dvd_q, qbit};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B != '0) begin
                        dvd_d   = bus.A;
                        dvs_d   = bus.B;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end else begin
                        p_d    = {{WIDTH{1'b1}}, bus.A};
                        dz_d   = 1'b1;
                        adiv_d = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = qbit ? trial[WIDTH-1:0] : ext[WIDTH-1:0];
                dvd_d = dvd_shift[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    p_d     = {dvd_d, rem_d};
                    dz_d    = 1'b0;
                    adiv_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            p_q     <= '0;
            adiv_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            p_q     <= p_d;
            adiv_q  <= adiv_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == CALC);
    assign bus.P        = p_q;
    assign bus.aDiv     = adiv_q;
    assign bus.div_zero = dz_q;
endmodule
